// File: rtl/core_lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, operand sizes and
// the alignment rule used when accepting a request.
package core_lsu_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    function automatic logic is_misaligned(size_t size, logic [1:0] lo);
        case (size)
            SZ_HALF: return lo[0];
            SZ_WORD: return |lo;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Byte-lane formatting for stores and lane extraction with sign/zero
// extension for loads. Purely combinational.
module core_lsu_align
    import core_lsu_pkg::*;
(
    input  logic [1:0]      size,
    input  logic            is_store,
    input  logic            is_unsigned,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] store_data,
    input  logic [XLEN-1:0] rdata,
    output logic [3:0]      wstrb,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] load_data
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        case (addr_lo)
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
        rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        wstrb     = 4'b0000;
        wdata     = '0;
        load_data = '0;
        if (is_store) begin
            case (size)
                SZ_BYTE: begin
                    wstrb = 4'b0001 << addr_lo;
                    wdata = {4{store_data[7:0]}};
                end
                SZ_HALF: begin
                    wstrb = 4'b0011 << addr_lo;
                    wdata = {2{store_data[15:0]}};
                end
                default: begin
                    wstrb = 4'b1111;
                    wdata = store_data;
                end
            endcase
        end else begin
            case (size)
                SZ_BYTE: load_data = is_unsigned ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
                SZ_HALF: load_data = is_unsigned ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
                default: load_data = rdata;
            endcase
        end
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: accepts one decoded memory op from the ALU stage, runs a
// single REQ/ACK bus transaction and reports completion status.
module core_lsu
    import core_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        rst_n,
    input  logic        clk,
    input  logic        VALID,
    input  logic        I_LB,
    input  logic        I_LH,
    input  logic        I_LW,
    input  logic        I_LBU,
    input  logic        I_LHU,
    input  logic        I_SB,
    input  logic        I_SH,
    input  logic        I_SW,
    input  logic [31:0] ADDR,
    input  logic [31:0] STORE_DATA,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [3:0]  MEM_WSTRB,
    output logic [31:0] MEM_WDATA,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] LOAD_DATA,
    output logic        MISALIGN,
    output logic        BUS_ERR
);

    state_t          state, next_state;
    size_t           dec_size, op_size;
    logic            dec_store, dec_unsigned, op_store, op_unsigned;
    logic [3:0]      n_flags;
    logic            dec_mis;
    logic            accept, illegal, ack_done, timeout_hit;
    logic [XLEN-1:0] addr_q, sdata_q, load_q, cnt;
    logic            misalign_q, bus_err_q;
    logic [3:0]      al_wstrb;
    logic [XLEN-1:0] al_wdata, al_load;

    assign n_flags = 4'($countones({I_LB, I_LH, I_LW, I_LBU, I_LHU, I_SB, I_SH, I_SW}));

    always_comb begin
        dec_size = SZ_WORD;
        if (I_LB || I_LBU || I_SB)
            dec_size = SZ_BYTE;
        else if (I_LH || I_LHU || I_SH)
            dec_size = SZ_HALF;
        dec_store    = I_SB || I_SH || I_SW;
        dec_unsigned = I_LBU || I_LHU;
    end

    assign dec_mis = is_misaligned(dec_size, ADDR[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Bus outputs are driven only while the request is outstanding.
    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        illegal     = 1'b0;
        ack_done    = 1'b0;
        timeout_hit = 1'b0;
        MEM_REQ     = 1'b0;
        MEM_WE      = 1'b0;
        MEM_ADDR    = '0;
        MEM_WSTRB   = 4'b0000;
        MEM_WDATA   = '0;
        BUSY        = 1'b1;
        DONE        = 1'b0;
        case (state)
            IDLE: begin
                BUSY = 1'b0;
                if (VALID && n_flags == 4'd1) begin
                    accept     = 1'b1;
                    next_state = dec_mis ? RESP : ACCESS;
                end else if (VALID && n_flags > 4'd1) begin
                    illegal    = 1'b1;
                    next_state = RESP;
                end
            end
            ACCESS: begin
                MEM_REQ   = 1'b1;
                MEM_WE    = op_store;
                MEM_ADDR  = {addr_q[XLEN-1:2], 2'b00};
                MEM_WSTRB = al_wstrb;
                MEM_WDATA = al_wdata;
                if (MEM_ACK) begin
                    ack_done   = 1'b1;
                    next_state = RESP;
                end else if (TIMEOUT != 0 && cnt + 32'd1 == TIMEOUT) begin
                    timeout_hit = 1'b1;
                    next_state  = RESP;
                end
            end
            RESP: begin
                DONE       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_size     <= SZ_BYTE;
            op_store    <= 1'b0;
            op_unsigned <= 1'b0;
            addr_q      <= '0;
            sdata_q     <= '0;
            load_q      <= '0;
            cnt         <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            if (accept || illegal) begin
                load_q     <= '0;
                misalign_q <= accept && dec_mis;
                bus_err_q  <= illegal;
                cnt        <= '0;
            end
            if (accept) begin
                op_size     <= dec_size;
                op_store    <= dec_store;
                op_unsigned <= dec_unsigned;
                addr_q      <= ADDR;
                sdata_q     <= STORE_DATA;
            end
            if (ack_done)
                load_q <= al_load;
            if (state == ACCESS && !MEM_ACK)
                cnt <= cnt + 32'd1;
            if (timeout_hit)
                bus_err_q <= 1'b1;
        end
    end

    core_lsu_align u_align (
        .size        (op_size),
        .is_store    (op_store),
        .is_unsigned (op_unsigned),
        .addr_lo     (addr_q[1:0]),
        .store_data  (sdata_q),
        .rdata       (MEM_RDATA),
        .wstrb       (al_wstrb),
        .wdata       (al_wdata),
        .load_data   (al_load)
    );

    assign LOAD_DATA = load_q;
    assign MISALIGN  = misalign_q;
    assign BUS_ERR   = bus_err_q;

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: directed vector table, hand-written
// corner sequences and random transactions against a behavioural model.
module tb_core_lsu;

    localparam int TO = 16;

    localparam logic [7:0] F_LB  = 8'h01;
    localparam logic [7:0] F_LH  = 8'h02;
    localparam logic [7:0] F_LW  = 8'h04;
    localparam logic [7:0] F_LBU = 8'h08;
    localparam logic [7:0] F_LHU = 8'h10;
    localparam logic [7:0] F_SB  = 8'h20;
    localparam logic [7:0] F_SH  = 8'h40;
    localparam logic [7:0] F_SW  = 8'h80;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        VALID = 1'b0;
    logic        I_LB = 1'b0, I_LH = 1'b0, I_LW = 1'b0, I_LBU = 1'b0;
    logic        I_LHU = 1'b0, I_SB = 1'b0, I_SH = 1'b0, I_SW = 1'b0;
    logic [31:0] ADDR = '0, STORE_DATA = '0, MEM_RDATA = '0;
    logic        MEM_ACK = 1'b0;
    logic        MEM_REQ, MEM_WE, BUSY, DONE, MISALIGN, BUS_ERR;
    logic [31:0] MEM_ADDR, MEM_WDATA, LOAD_DATA;
    logic [3:0]  MEM_WSTRB;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    core_lsu #(.TIMEOUT(TO)) dut (
        .rst_n(rst_n), .clk(clk), .VALID(VALID),
        .I_LB(I_LB), .I_LH(I_LH), .I_LW(I_LW), .I_LBU(I_LBU),
        .I_LHU(I_LHU), .I_SB(I_SB), .I_SH(I_SH), .I_SW(I_SW),
        .ADDR(ADDR), .STORE_DATA(STORE_DATA),
        .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WSTRB(MEM_WSTRB), .MEM_WDATA(MEM_WDATA),
        .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK),
        .BUSY(BUSY), .DONE(DONE), .LOAD_DATA(LOAD_DATA),
        .MISALIGN(MISALIGN), .BUS_ERR(BUS_ERR)
    );

    typedef struct {
        int          done_at;
        int          req;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] maddr;
        logic [31:0] load;
        logic        mis;
        logic        berr;
        logic        unstable;
    } res_t;

    typedef struct {
        string       nm;
        logic [7:0]  fl;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          dly;
        res_t        e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic set_flags(input logic [7:0] f);
        {I_SW, I_SH, I_SB, I_LHU, I_LBU, I_LW, I_LH, I_LB} = f;
    endtask

    function automatic res_t er(int done_at, int req, logic we, logic [3:0] ws,
                                logic [31:0] wd, logic [31:0] ma, logic [31:0] ld,
                                logic mis, logic berr);
        res_t r;
        r.done_at = done_at; r.req = req; r.we = we; r.wstrb = ws; r.wdata = wd;
        r.maddr = ma; r.load = ld; r.mis = mis; r.berr = berr; r.unstable = 1'b0;
        return r;
    endfunction

    function automatic vec_t mk(string nm, logic [7:0] fl, logic [31:0] a, logic [31:0] sd,
                                logic [31:0] rd, int dly, res_t e);
        vec_t v;
        v.nm = nm; v.fl = fl; v.a = a; v.sd = sd; v.rd = rd; v.dly = dly; v.e = e;
        return v;
    endfunction

    // Reference model: sizes in bytes, lane offsets and masks by arithmetic.
    function automatic res_t model(logic [7:0] fl, logic [31:0] a, logic [31:0] sd,
                                   logic [31:0] rd, int dly);
        res_t        r;
        int          n, sz, off;
        bit          st, sg;
        logic [31:0] mask, v;
        r = er(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n = $countones(fl);
        if (n == 0) return r;
        if (n > 1) begin
            r.done_at = 1; r.berr = 1'b1;
            return r;
        end
        sz = (fl & (F_LB | F_LBU | F_SB)) != 0 ? 1 : (fl & (F_LH | F_LHU | F_SH)) != 0 ? 2 : 4;
        st = (fl & (F_SB | F_SH | F_SW)) != 0;
        sg = (fl & (F_LB | F_LH)) != 0;
        off = int'(a % 4);
        if (a % sz != 0) begin
            r.done_at = 1; r.mis = 1'b1;
            return r;
        end
        r.maddr = a - (a % 4);
        r.we    = st;
        if (st) begin
            r.wstrb = 4'(((1 << sz) - 1) << off);
            for (int i = 0; i < 4; i++)
                r.wdata[8*i +: 8] = sd[8*(i % sz) +: 8];
        end
        if (dly < 0 || dly >= TO) begin
            r.req = TO; r.done_at = TO + 1; r.berr = 1'b1;
        end else begin
            r.req = dly + 1; r.done_at = dly + 2;
            if (!st) begin
                mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
                v = (rd >> (8*off)) & mask;
                if (sg && v[8*sz-1]) v = v | ~mask;
                r.load = v;
            end
        end
        return r;
    endfunction

    // Issue one VALID, play the memory side, and observe until DONE.
    task automatic run_txn(input logic [7:0] fl, input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input int dly, input bit poke, output res_t o);
        o = er(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        set_flags(fl); ADDR = a; STORE_DATA = sd; MEM_RDATA = rd; VALID = 1'b1;
        @(negedge clk);
        VALID = 1'b0; set_flags(8'h00); ADDR = $urandom; STORE_DATA = $urandom;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (poke && k == 2) begin
                VALID = 1'b1; set_flags(F_SW); ADDR = 32'hFFFF_FFF0;
            end else if (poke && k == 3) begin
                VALID = 1'b0; set_flags(8'h00);
            end
            MEM_ACK = 1'b0;
            if (MEM_REQ) begin
                o.req++;
                if (o.req == 1) begin
                    o.we = MEM_WE; o.wstrb = MEM_WSTRB; o.wdata = MEM_WDATA; o.maddr = MEM_ADDR;
                end else if (o.we !== MEM_WE || o.wstrb !== MEM_WSTRB ||
                             o.wdata !== MEM_WDATA || o.maddr !== MEM_ADDR) begin
                    o.unstable = 1'b1;
                end
                if (dly >= 0 && o.req == dly + 1) MEM_ACK = 1'b1;
            end
            if (DONE) begin
                o.done_at = k; o.load = LOAD_DATA; o.mis = MISALIGN; o.berr = BUS_ERR;
                break;
            end
        end
        MEM_ACK = 1'b0;
        VALID   = 1'b0;
    endtask

    task automatic cmp_res(input string tag, input res_t o, input res_t e);
        chk({tag, ".done_at"}, o.done_at, e.done_at);
        chk({tag, ".req_cycles"}, o.req, e.req);
        if (e.done_at != 0) begin
            chk({tag, ".misalign"}, o.mis, e.mis);
            chk({tag, ".bus_err"}, o.berr, e.berr);
            chk({tag, ".load_data"}, o.load, e.load);
        end
        if (e.req > 0) begin
            chk({tag, ".mem_addr"}, o.maddr, e.maddr);
            chk({tag, ".we"}, o.we, e.we);
            chk({tag, ".wstrb"}, o.wstrb, e.wstrb);
            chk({tag, ".stable"}, o.unstable, 1'b0);
            if (e.we) chk({tag, ".wdata"}, o.wdata, e.wdata);
        end
        if (e.done_at != 0) begin
            @(negedge clk);
            chk({tag, ".done_pulse"}, {DONE, BUSY}, 2'b00);
            chk({tag, ".hold_status"}, {LOAD_DATA, MISALIGN, BUS_ERR}, {e.load, e.mis, e.berr});
        end
    endtask

    vec_t        tbl[13];
    res_t        o, e;
    logic [7:0]  fl;
    logic [31:0] a;
    int          dly, seen;

    initial begin
        tbl[0]  = mk("lb_sign", F_LB, 32'h1003, 32'h0, 32'h80AABBCC, 0,
                     er(2, 1, 0, 4'b0000, 0, 32'h1000, 32'hFFFFFF80, 0, 0));
        tbl[1]  = mk("lhu_wait3", F_LHU, 32'h102, 32'h0, 32'h9ABC1234, 3,
                     er(5, 4, 0, 4'b0000, 0, 32'h100, 32'h00009ABC, 0, 0));
        tbl[2]  = mk("sb_lane1", F_SB, 32'h201, 32'h123456A5, 32'hFFFFFFFF, 0,
                     er(2, 1, 1, 4'b0010, 32'hA5A5A5A5, 32'h200, 0, 0, 0));
        tbl[3]  = mk("sh_hi", F_SH, 32'h202, 32'hDEADBEEF, 32'h0, 1,
                     er(3, 2, 1, 4'b1100, 32'hBEEFBEEF, 32'h200, 0, 0, 0));
        tbl[4]  = mk("lw_mis", F_LW, 32'h6, 32'h0, 32'h12345678, 0,
                     er(1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl[5]  = mk("sh_mis", F_SH, 32'h3, 32'h5555AAAA, 32'h0, 0,
                     er(1, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl[6]  = mk("sw_timeout", F_SW, 32'h10, 32'h11223344, 32'h0, -1,
                     er(17, 16, 1, 4'b1111, 32'h11223344, 32'h10, 0, 0, 1));
        tbl[7]  = mk("illegal", F_LB | F_SW, 32'h40, 32'h0, 32'h0, 0,
                     er(1, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl[8]  = mk("no_flags", 8'h00, 32'h44, 32'h0, 32'h0, 0,
                     er(0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl[9]  = mk("lh_hi_sign", F_LH, 32'h2, 32'h0, 32'h80017FFF, 2,
                     er(4, 3, 0, 4'b0000, 0, 32'h0, 32'hFFFF8001, 0, 0));
        tbl[10] = mk("lw_ack_last", F_LW, 32'h8, 32'h0, 32'hCAFEF00D, 15,
                     er(17, 16, 0, 4'b0000, 0, 32'h8, 32'hCAFEF00D, 0, 0));
        tbl[11] = mk("lbu_lane1", F_LBU, 32'h1001, 32'h0, 32'h00008000, 0,
                     er(2, 1, 0, 4'b0000, 0, 32'h1000, 32'h00000080, 0, 0));
        tbl[12] = mk("sw_word", F_SW, 32'h7FFC, 32'h0BADF00D, 32'h0, 2,
                     er(4, 3, 1, 4'b1111, 32'h0BADF00D, 32'h7FFC, 0, 0, 0));

        repeat (2) @(negedge clk);
        chk("reset_ctrl", {MEM_REQ, MEM_WE, BUSY, DONE, MISALIGN, BUS_ERR}, 6'b0);
        chk("reset_bus", {MEM_ADDR, MEM_WSTRB}, 36'h0);
        chk("reset_data", {MEM_WDATA, LOAD_DATA}, 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_txn(tbl[i].fl, tbl[i].a, tbl[i].sd, tbl[i].rd, tbl[i].dly, 1'b0, o);
            cmp_res(tbl[i].nm, o, tbl[i].e);
        end

        // Reset pulsed while a load waits for ACK.
        @(negedge clk);
        set_flags(F_LW); ADDR = 32'h20; VALID = 1'b1;
        @(negedge clk);
        VALID = 1'b0; set_flags(8'h00);
        chk("midrst.req_before", MEM_REQ, 1'b1);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst.req_drop", MEM_REQ, 1'b0);
        chk("midrst.busy_drop", BUSY, 1'b0);
        chk("midrst.status_clr", {LOAD_DATA, MISALIGN, BUS_ERR}, 34'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (DONE || MEM_REQ) seen++;
        end
        chk("midrst.no_done", seen, 0);
        run_txn(F_LW, 32'h24, 32'h0, 32'h13579BDF, 1, 1'b0, o);
        cmp_res("after_rst", o, model(F_LW, 32'h24, 32'h0, 32'h13579BDF, 1));

        // VALID pulsed during ACCESS must not disturb the transaction.
        run_txn(F_LW, 32'h40, 32'h0, 32'h55AA00FF, 4, 1'b1, o);
        cmp_res("valid_busy", o, model(F_LW, 32'h40, 32'h0, 32'h55AA00FF, 4));

        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 19))
                0: fl = 8'h00;
                1: begin
                    int i0, i1;
                    i0 = $urandom_range(0, 7);
                    i1 = (i0 + $urandom_range(1, 7)) % 8;
                    fl = (8'h01 << i0) | (8'h01 << i1);
                end
                default: fl = 8'h01 << $urandom_range(0, 7);
            endcase
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            case ($urandom_range(0, 9))
                0: dly = -1;
                1: dly = $urandom_range(14, 20);
                default: dly = $urandom_range(0, 4);
            endcase
            e = model(fl, a, $urandom, 32'h0, dly);
            begin
                logic [31:0] sd, rd;
                sd = $urandom; rd = $urandom;
                e = model(fl, a, sd, rd, dly);
                run_txn(fl, a, sd, rd, dly, 1'b0, o);
                cmp_res($sformatf("rand%0d", t), o, e);
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
